// File: rtl/ooo_fetch_pkg.sv
// Shared fetch-path types and constants: the packet carried from fetch to
// decode, the fetch controller state encoding and a PC alignment helper.
package ooo_fetch_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } fetch_pkt_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    // Instructions are word aligned; the two low PC bits are always zero.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetch packets between the imem response and decode.
// Push and pop may happen in the same cycle even when full or empty; flush
// empties the FIFO and overrides any push/pop in that cycle.
module fetch_buf
    import ooo_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_pkt_t       push_pkt,
    input  logic             pop,
    input  logic             flush,
    output fetch_pkt_t       head_pkt,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_pkt_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign head_pkt = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a push into a full FIFO only lands if a pop frees a slot.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Storage entry gi captures the pushed packet when the write pointer selects it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (do_push && !flush && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= push_pkt;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch initiator for imem RW port 0. Keeps the PC, issues one
// word read per cycle while the output buffer has room, captures the SRAM
// response one cycle later and hands {inst, pc} to decode via valid/ready.
// Redirects flush the buffer and bump an epoch so stale responses are dropped.
// Optional feature macro: IMEM_FETCH_LOAD_EN adds a word-write load port
// usable while idle.
module imem_fetch_ctrl
    import ooo_fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef IMEM_FETCH_LOAD_EN
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
`endif
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  imem_csb0,
    output logic                  imem_web0,
    output logic [ADDR_WIDTH-1:0] imem_addr0,
    output logic [DATA_WIDTH-1:0] imem_din0,
    input  logic [DATA_WIDTH-1:0] imem_dout0,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [31:0]           inst_pc
);

    // The PC only spans the imem byte range, so increments wrap naturally.
    localparam int               PC_W       = ADDR_WIDTH + 2;
    localparam int               CNT_W      = $clog2(BUF_DEPTH + 1);
    localparam logic [PC_W-1:0]  RESET_PC_W = PC_W'(align_pc(RESET_PC));
    localparam logic [CNT_W:0]   DEPTH_W    = (CNT_W + 1)'(BUF_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            req_epoch_q, req_epoch_d;
    logic            epoch_q, epoch_d;

    fetch_pkt_t       head_pkt;
    fetch_pkt_t       push_pkt;
    logic [CNT_W-1:0] buf_count;
    logic             buf_empty;
    logic             buf_full;
    logic             buf_push;
    logic             buf_pop;

    logic            pop;
    logic            issue;
    logic            load_fire;
    logic [CNT_W:0]  occupancy;
    logic [CNT_W:0]  room_limit;

    // Redirect targets outside the imem byte range alias into it; low bits are forced to zero.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^{redirect_pc[31:PC_W], redirect_pc[1:0], buf_full};

`ifdef IMEM_FETCH_LOAD_EN
    logic load_ready_q, load_ready_d;
    assign load_ready = load_ready_q;
    assign load_fire  = load_valid && load_ready_q;
`else
    assign load_fire  = 1'b0;
`endif

    assign inst_valid = !buf_empty;
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = inst_valid ? DATA_WIDTH'(head_pkt.inst) : '0;
    assign inst_pc    = inst_valid ? head_pkt.pc : '0;

    // Issue decision and imem port drive; a slot freed by this cycle's pop counts as room.
    always_comb begin
        occupancy  = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q};
        room_limit = DEPTH_W + {{CNT_W{1'b0}}, pop};
        issue      = (state_q == FETCH) && !redirect_valid && (occupancy < room_limit);
        imem_csb0  = !(issue || load_fire);
        imem_addr0 = issue ? pc_q[PC_W-1:2] : '0;
`ifdef IMEM_FETCH_LOAD_EN
        imem_web0  = !load_fire;
        imem_din0  = load_fire ? load_data : '0;
        if (load_fire) begin
            imem_addr0 = load_addr;
        end
`else
        imem_web0  = 1'b1;
        imem_din0  = '0;
`endif
    end

    // Response capture into the buffer; redirect or epoch change discards it.
    always_comb begin
        push_pkt.inst = INST_W'(imem_dout0);
        push_pkt.pc   = XLEN'(req_pc_q);
        buf_push      = inflight_q && (req_epoch_q == epoch_q) && !redirect_valid;
        buf_pop       = pop && !redirect_valid;
    end

    // Next-state for the FSM, PC, request tracking and epoch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inflight_d  = issue;
        req_pc_d    = req_pc_q;
        req_epoch_d = req_epoch_q;
        epoch_d     = epoch_q ^ redirect_valid;
        case (state_q)
            IDLE:    if (fetch_en && !load_fire) state_d = FETCH;
            FETCH:   if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (issue) begin
            pc_d        = pc_q + PC_W'(4);
            req_pc_d    = pc_q;
            req_epoch_d = epoch_q;
        end
        if (redirect_valid) begin
            pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        end
`ifdef IMEM_FETCH_LOAD_EN
        load_ready_d = (state_d == IDLE) && !inflight_d;
`endif
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC_W;
            inflight_q   <= 1'b0;
            req_pc_q     <= '0;
            req_epoch_q  <= 1'b0;
            epoch_q      <= 1'b0;
`ifdef IMEM_FETCH_LOAD_EN
            load_ready_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            req_pc_q     <= req_pc_d;
            req_epoch_q  <= req_epoch_d;
            epoch_q      <= epoch_d;
`ifdef IMEM_FETCH_LOAD_EN
            load_ready_q <= load_ready_d;
`endif
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (buf_push),
        .push_pkt (push_pkt),
        .pop      (buf_pop),
        .flush    (redirect_valid),
        .head_pkt (head_pkt),
        .count    (buf_count),
        .empty    (buf_empty),
        .full     (buf_full)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl with a behavioural one-cycle SRAM.
// Expected {inst, pc} packets are queued by each scenario and compared by a
// scoreboard on every accepted handshake. Define IMEM_FETCH_LOAD_EN to also
// exercise the load port.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_csb0;
    logic        imem_web0;
    logic [7:0]  imem_addr0;
    logic [31:0] imem_din0;
    logic [31:0] imem_dout0 = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef IMEM_FETCH_LOAD_EN
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [7:0]  load_addr = 8'h0;
    logic [31:0] load_data = 32'h0;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [256];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef IMEM_FETCH_LOAD_EN
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_addr      (load_addr),
        .load_data      (load_data),
`endif
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_csb0      (imem_csb0),
        .imem_web0      (imem_web0),
        .imem_addr0     (imem_addr0),
        .imem_din0      (imem_din0),
        .imem_dout0     (imem_dout0),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 + i * 32'h0001_0001;
        mem[0] = 32'h0051_8093;
        mem[1] = 32'h4020_8133;
    end

    // SRAM model: read data valid only for the cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        if (!imem_csb0 && imem_web0) imem_dout0 <= mem[imem_addr0];
        else                         imem_dout0 <= $urandom;
        if (!imem_csb0 && !imem_web0) mem[imem_addr0] <= imem_din0;
    end

    // Scoreboard: compare every accepted instruction against the queue head.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_inst got pc=%h inst=%h required none", inst_pc, inst_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({inst_data, inst_pc} !== e) begin
                    errors++;
                    $display("FAIL inst_pkt got pc=%h inst=%h required pc=%h inst=%h",
                             inst_pc, inst_data, e[31:0], e[63:32]);
                end else begin
                    $display("xfer pc=%h inst=%h ok", inst_pc, inst_data);
                end
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({mem[pc[9:2]], pc});
    endtask

    // Holds reset for 4 edges; returns at the start of the first released cycle.
    task automatic do_reset;
        rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
`ifdef IMEM_FETCH_LOAD_EN
        load_valid = 1'b0;
`endif
        repeat (4) next_cycle();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) next_cycle();
        repeat (3) next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        checks++; if (imem_csb0 !== 1'b1)   begin errors++; $display("FAIL rst_csb0 got %b required 1", imem_csb0); end
        checks++; if (imem_web0 !== 1'b1)   begin errors++; $display("FAIL rst_web0 got %b required 1", imem_web0); end
        checks++; if (imem_addr0 !== 8'h0)  begin errors++; $display("FAIL rst_addr0 got %h required 00", imem_addr0); end
        checks++; if (imem_din0 !== 32'h0)  begin errors++; $display("FAIL rst_din0 got %h required 0", imem_din0); end
        checks++; if (inst_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got %b required 0", inst_valid); end
        checks++; if (inst_data !== 32'h0)  begin errors++; $display("FAIL rst_data got %h required 0", inst_data); end
        checks++; if (inst_pc !== 32'h0)    begin errors++; $display("FAIL rst_pc got %h required 0", inst_pc); end
        $display("test_reset done");
    endtask

    task automatic test_fetch;
        do_reset();
        fetch_en = 1'b1;
        for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
        @(negedge clk);
        checks++; if (imem_csb0 !== 1'b1) begin errors++; $display("FAIL fetch_idle_csb0 got %b required 1", imem_csb0); end
        next_cycle(); @(negedge clk);
        checks++; if (imem_csb0 !== 1'b0 || imem_addr0 !== 8'd0)
            begin errors++; $display("FAIL fetch_req0 got csb0=%b addr=%0d required csb0=0 addr=0", imem_csb0, imem_addr0); end
        next_cycle(); @(negedge clk);
        checks++; if (imem_csb0 !== 1'b0 || imem_addr0 !== 8'd1)
            begin errors++; $display("FAIL fetch_req1 got csb0=%b addr=%0d required csb0=0 addr=1", imem_csb0, imem_addr0); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid got %b required 0", inst_valid); end
        next_cycle(); @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_data !== 32'h0051_8093)
            begin errors++; $display("FAIL fetch_first got valid=%b inst=%h required 1 00518093", inst_valid, inst_data); end
        next_cycle(); next_cycle(); next_cycle();
        fetch_en = 1'b0;
        drain("fetch");
        $display("test_fetch done");
    endtask

    task automatic test_backpressure;
        int reads;
        reads = 0;
        do_reset();
        inst_ready = 1'b0; fetch_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!imem_csb0) reads++;
            next_cycle();
        end
        @(negedge clk);
        checks++; if (reads != 2) begin errors++; $display("FAIL bp_reads got %0d required 2", reads); end
        checks++; if (imem_csb0 !== 1'b1 || inst_valid !== 1'b1)
            begin errors++; $display("FAIL bp_stall got csb0=%b valid=%b required 1 1", imem_csb0, inst_valid); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL bp_hold_pc got %h required 0", inst_pc); end
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
        next_cycle();
        inst_ready = 1'b1;
        repeat (5) next_cycle();
        fetch_en = 1'b0;
        drain("bp");
        $display("test_backpressure done");
    endtask

    task automatic test_redirect;
        do_reset();
        fetch_en = 1'b1;
        next_cycle(); @(negedge clk);
        checks++; if (imem_csb0 !== 1'b0 || imem_addr0 !== 8'd0)
            begin errors++; $display("FAIL rd_req0 got csb0=%b addr=%0d required 0 0", imem_csb0, imem_addr0); end
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0023;
        @(negedge clk);
        checks++; if (imem_csb0 !== 1'b1) begin errors++; $display("FAIL rd_no_issue got %b required 1", imem_csb0); end
        push_exp(32'h20); push_exp(32'h24);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_csb0 !== 1'b0 || imem_addr0 !== 8'd8)
            begin errors++; $display("FAIL rd_new_req got csb0=%b addr=%0d required 0 8", imem_csb0, imem_addr0); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_dropped got valid=%b required 0", inst_valid); end
        next_cycle();
        fetch_en = 1'b0;
        drain("redirect");
        $display("test_redirect done");
    endtask

    task automatic test_wrap;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_03FC; fetch_en = 1'b1;
        push_exp(32'h3FC); push_exp(32'h000);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_csb0 !== 1'b0 || imem_addr0 !== 8'd255)
            begin errors++; $display("FAIL wrap_a got csb0=%b addr=%0d required 0 255", imem_csb0, imem_addr0); end
        next_cycle();
        fetch_en = 1'b0;
        @(negedge clk);
        checks++; if (imem_csb0 !== 1'b0 || imem_addr0 !== 8'd0)
            begin errors++; $display("FAIL wrap_b got csb0=%b addr=%0d required 0 0", imem_csb0, imem_addr0); end
        drain("wrap");
        $display("test_wrap done");
    endtask

    task automatic test_reset_midop;
        do_reset();
        inst_ready = 1'b0; fetch_en = 1'b1;
        repeat (6) next_cycle();
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL mid_full got valid=%b required 1", inst_valid); end
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0 || imem_csb0 !== 1'b1)
            begin errors++; $display("FAIL mid_rst got valid=%b csb0=%b required 0 1", inst_valid, imem_csb0); end
        push_exp(32'h0); push_exp(32'h4);
        next_cycle();
        inst_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_csb0 !== 1'b0 || imem_addr0 !== 8'd0)
            begin errors++; $display("FAIL mid_refetch got csb0=%b addr=%0d required 0 0", imem_csb0, imem_addr0); end
        next_cycle();
        fetch_en = 1'b0;
        drain("midop");
        $display("test_reset_midop done");
    endtask

`ifdef IMEM_FETCH_LOAD_EN
    task automatic test_load;
        do_reset();
        @(negedge clk);
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ld_rst_ready got %b required 0", load_ready); end
        next_cycle();
        load_valid = 1'b1; load_addr = 8'd5; load_data = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL ld_ready got %b required 1", load_ready); end
        checks++; if (imem_csb0 !== 1'b0 || imem_web0 !== 1'b0 || imem_addr0 !== 8'd5 || imem_din0 !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL ld_write got csb0=%b web0=%b addr=%0d din=%h required 0 0 5 deadbeef",
                                     imem_csb0, imem_web0, imem_addr0, imem_din0); end
        next_cycle();
        load_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_csb0 !== 1'b1 || imem_web0 !== 1'b1)
            begin errors++; $display("FAIL ld_done got csb0=%b web0=%b required 1 1", imem_csb0, imem_web0); end
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h14; fetch_en = 1'b1;
        exp_q.push_back({32'hDEAD_BEEF, 32'h14});
        next_cycle();
        redirect_valid = 1'b0; fetch_en = 1'b0;
        @(negedge clk);
        checks++; if (imem_csb0 !== 1'b0 || imem_web0 !== 1'b1 || imem_addr0 !== 8'd5)
            begin errors++; $display("FAIL ld_read got csb0=%b web0=%b addr=%0d required 0 1 5", imem_csb0, imem_web0, imem_addr0); end
        drain("load");
        $display("test_load done");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_midop();
`ifdef IMEM_FETCH_LOAD_EN
        test_load();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
